// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_pkg
// Brief    : Shared sizing constants and mixer state encoding for osc_mixer.
// Revision : 1.0 - initial release
// ============================================================================
package osc_pkg;

    localparam int unsigned N       = 10;
    localparam int unsigned AMP     = 25;
    localparam int unsigned c_CNT_W = 20;
    localparam int unsigned c_NUM_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } mixer_state_t;

endpackage
`default_nettype wire

// File: rtl/osc_mixer_if.sv
`default_nettype none
// ============================================================================
// Module   : osc_mixer_if
// Brief    : Sample request, voice selector and mixed-sample bus of osc_mixer.
// Revision : 1.0 - initial release
// ============================================================================
interface osc_mixer_if
    import osc_pkg::*;
#(
    parameter int unsigned N = osc_pkg::N
);
    logic               sample_tick;
    logic [N-1:0]       osc_en;
    logic [c_CNT_W-1:0] count_sel;
    logic [c_CNT_W-1:0] max_sel;
    logic [c_NUM_W-1:0] osc_num;
    logic [7:0]         sample;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    // master is the mixer; slave is the requester plus oscillator selector
    modport master (
        input  sample_tick, osc_en, count_sel, max_sel,
        output osc_num, sample, sample_valid, busy, overrun
    );

    modport slave (
        output sample_tick, osc_en, count_sel, max_sel,
        input  osc_num, sample, sample_valid, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/voice_gate.sv
`default_nettype none
// ============================================================================
// Module   : voice_gate
// Brief    : Square-wave gate: voice is high in the first half of its period.
// Revision : 1.0 - initial release
// ============================================================================
module voice_gate
    import osc_pkg::*;
(
    input  logic               en,
    input  logic [c_CNT_W-1:0] count,
    input  logic [c_CNT_W-1:0] max,
    output logic               high
);

    // a period of 0 or 1 has an empty high half, so such voices stay silent
    assign high = en && (max != '0) && (count < (max >> 1));

endmodule
`default_nettype wire

// File: rtl/osc_mixer.sv
`default_nettype none
// ============================================================================
// Module   : osc_mixer
// Brief    : Scans N oscillators per sample tick and sums active voices.
// Revision : 1.0 - initial release
// ============================================================================
module osc_mixer
    import osc_pkg::*;
#(
    parameter int unsigned N   = osc_pkg::N,
    parameter int unsigned AMP = osc_pkg::AMP
)(
    input  logic        clk,
    input  logic        rst,
    osc_mixer_if.master bus
);

    localparam logic [7:0]         c_AMP8 = 8'(AMP);
    localparam logic [c_NUM_W-1:0] c_LAST = c_NUM_W'(N - 1);

    mixer_state_t       r_state;
    logic [c_NUM_W-1:0] r_osc_num;
    logic [7:0]         r_acc;
    logic [7:0]         r_sample;
    logic               r_sample_valid;
    logic               r_overrun;

    logic               w_en;
    logic               w_high;
    logic [7:0]         w_acc_next;

    always_comb begin
        w_en = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_osc_num == c_NUM_W'(i)) begin
                w_en = bus.osc_en[i];
            end
        end
    end

    voice_gate u_voice_gate (
        .en    (w_en),
        .count (bus.count_sel),
        .max   (bus.max_sel),
        .high  (w_high)
    );

    // N*AMP fits in 8 bits, so the sum never wraps
    assign w_acc_next = r_acc + (w_high ? c_AMP8 : 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_osc_num      <= '0;
            r_acc          <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_overrun      <= bus.sample_tick && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.sample_tick) begin
                        r_acc     <= '0;
                        r_osc_num <= '0;
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    r_acc <= w_acc_next;
                    if (r_osc_num == c_LAST) begin
                        // publish during DONE so sample and its strobe coincide
                        r_osc_num      <= '0;
                        r_sample       <= w_acc_next;
                        r_sample_valid <= 1'b1;
                        r_state        <= DONE;
                    end else begin
                        r_osc_num <= r_osc_num + 1'b1;
                    end
                end
                DONE: begin
                    r_osc_num <= '0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_osc_num <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.osc_num      = r_osc_num;
    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_sample_valid;
    assign bus.overrun      = r_overrun;
    assign bus.busy         = (r_state == SCAN) || (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_osc_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_mixer
// Brief    : Directed plus randomized self-checking bench for osc_mixer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_mixer;
    import osc_pkg::*;

    localparam int NV   = 10;
    localparam int AMPV = 25;

    logic tb_clk = 1'b0;
    logic rst;
    always #5 tb_clk = ~tb_clk;

    osc_mixer_if #(.N(NV)) bus ();

    osc_mixer #(.N(NV), .AMP(AMPV)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    int cnt_arr [NV];
    int max_arr [NV];
    int tests_run    = 0;
    int tests_failed = 0;

    // upstream oscillator selector
    always_comb begin
        bus.count_sel = '0;
        bus.max_sel   = '0;
        if (int'(bus.osc_num) < NV) begin
            bus.count_sel = 20'(cnt_arr[bus.osc_num]);
            bus.max_sel   = 20'(max_arr[bus.osc_num]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // square wave is high while count is below half the period
    function automatic int model(input logic [NV-1:0] en);
        int s = 0;
        for (int i = 0; i < NV; i++) begin
            if (en[i] && (cnt_arr[i] < max_arr[i] / 2)) s += AMPV;
        end
        return s;
    endfunction

    task automatic run_scan(input string tag, input int exp_s, input int retick_at);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        for (int j = 0; j < NV; j++) begin
            chk({tag, "/osc_num"}, 32'(bus.osc_num), 32'(j));
            chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "/valid_scan"}, 32'(bus.sample_valid), 32'd0);
            chk({tag, "/overrun"}, 32'(bus.overrun), 32'((j == retick_at) ? 1 : 0));
            if (j + 1 == retick_at) bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
        end
        chk({tag, "/osc_num_done"}, 32'(bus.osc_num), 32'd0);
        chk({tag, "/valid"}, 32'(bus.sample_valid), 32'd1);
        chk({tag, "/busy_done"}, 32'(bus.busy), 32'd1);
        chk({tag, "/sample"}, 32'(bus.sample), 32'(exp_s));
        chk({tag, "/overrun_done"}, 32'(bus.overrun), 32'd0);
        step();
        chk({tag, "/valid_off"}, 32'(bus.sample_valid), 32'd0);
        chk({tag, "/busy_off"}, 32'(bus.busy), 32'd0);
        chk({tag, "/osc_num_idle"}, 32'(bus.osc_num), 32'd0);
        chk({tag, "/sample_held"}, 32'(bus.sample), 32'(exp_s));
    endtask

    task automatic fill(input int c, input int m);
        for (int i = 0; i < NV; i++) begin
            cnt_arr[i] = c;
            max_arr[i] = m;
        end
    endtask

    initial begin
        int vcount;
        logic [NV-1:0] ren;

        rst             = 1'b1;
        bus.sample_tick = 1'b0;
        bus.osc_en      = '0;
        fill(0, 0);
        repeat (3) step();
        chk("reset/osc_num", 32'(bus.osc_num), 32'd0);
        chk("reset/sample", 32'(bus.sample), 32'd0);
        chk("reset/valid", 32'(bus.sample_valid), 32'd0);
        chk("reset/busy", 32'(bus.busy), 32'd0);
        chk("reset/overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // all voices high
        bus.osc_en = '1;
        fill(0, 100);
        run_scan("all_on", 250, -1);

        // reset in the middle of a scan
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        repeat (4) step();
        chk("midrst/osc_num_pre", 32'(bus.osc_num), 32'd4);
        rst = 1'b1;
        #1;
        chk("midrst/osc_num", 32'(bus.osc_num), 32'd0);
        chk("midrst/sample", 32'(bus.sample), 32'd0);
        chk("midrst/valid", 32'(bus.sample_valid), 32'd0);
        chk("midrst/busy", 32'(bus.busy), 32'd0);
        step();
        rst = 1'b0;
        vcount = 0;
        for (int k = 0; k < NV + 3; k++) begin
            step();
            vcount += int'(bus.sample_valid);
        end
        chk("midrst/no_valid", 32'(vcount), 32'd0);
        run_scan("after_rst", 250, -1);

        // two enabled voices, disabled voice would otherwise be low anyway
        bus.osc_en = 10'b0000000101;
        fill(10, 100);
        cnt_arr[1] = 60;
        run_scan("two_on", 50, -1);

        // degenerate periods and the count == half boundary
        bus.osc_en = 10'b0000001101;
        fill(0, 100);
        max_arr[0] = 1;
        max_arr[2] = 0;
        cnt_arr[3] = 50;
        run_scan("boundary", 0, -1);

        // re-tick three cycles into the scan
        bus.osc_en = '1;
        fill(0, 100);
        cnt_arr[5] = 70;
        run_scan("overrun", 225, 3);

        // randomized voices against the arithmetic model
        for (int r = 0; r < 8; r++) begin
            ren = NV'($urandom);
            for (int i = 0; i < NV; i++) begin
                cnt_arr[i] = int'($urandom_range(0, 25));
                max_arr[i] = int'($urandom_range(0, 40));
            end
            bus.osc_en = ren;
            run_scan("random", model(ren), -1);
            repeat (int'($urandom_range(0, 3))) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
